shift_arbiter: RTL and testbench

//  Shares the single combinational Shifter (LSL/LSR/ASR/ROR, 5-bit amount) between NUM_REQ requesters.

---
 rtl/shift_arbiter_pkg.sv | 13 +
 rtl/shift_arbiter_if.sv | 33 +++
 rtl/shift_arbiter_rr.sv | 41 ++++
 rtl/shift_arbiter_shifter.sv | 25 ++
 rtl/shift_arbiter.sv | 118 +++++++++++
 tb/tb_shift_arbiter.sv | 152 +++++++++++++++
 6 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared types for the shift arbiter slice.
// Shift encodings and operand widths.
package shift_pkg;
    typedef enum logic [1:0] {
        SH_LSL,
        SH_LSR,
        SH_ASR,
        SH_ROR
    } shift_t;

    localparam int AMT_W  = 8;
    localparam int DATA_W = 32;
endpackage

// File: rtl/shift_arbiter_if.sv
// Request/result bundle between requesters and the shift arbiter.
interface shift_arbiter_if
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*2-1:0]      req_type;
    logic [NUM_REQ*AMT_W-1:0]  req_amount;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_cin;
    logic                      res_valid;
    logic                      res_ready;
    logic [DATA_W-1:0]         res_data;
    logic                      res_carry;
    logic [ID_W-1:0]           res_id;

    modport master (
        output req_valid, req_type, req_amount,
        output req_data, req_cin, res_ready,
        input  req_ready, res_valid, res_data,
        input  res_carry, res_id
    );

    modport slave (
        input  req_valid, req_type, req_amount,
        input  req_data, req_cin, res_ready,
        output req_ready, res_valid, res_data,
        output res_carry, res_id
    );
endinterface

// File: rtl/shift_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searching upward from r_ptr.
// Pointer moves past the winner only when a grant is issued.
module shift_arbiter_rr #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_id,
    output logic               o_any
);
    logic [ID_W-1:0] r_ptr;
    int              w_idx;

    always_comb begin
        o_gnt = '0;
        o_id  = '0;
        o_any = 1'b0;
        w_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ)
                w_idx = w_idx - NUM_REQ;
            if (i_en && i_req[w_idx] && !o_any) begin
                o_gnt[w_idx] = 1'b1;
                o_id         = ID_W'(w_idx);
                o_any        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (o_any)
            r_ptr <= (o_id == ID_W'(NUM_REQ - 1)) ? '0 : o_id + ID_W'(1);
    end
endmodule

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter for a 5-bit amount.
// Boundary cases (0, >=32) are handled by the caller.
module shift_arbiter_shifter
    import shift_pkg::*;
(
    input  shift_t      i_type,
    input  logic [4:0]  i_n,
    input  logic [31:0] i_x,
    output logic [31:0] o_y
);
    logic [63:0] w_rot;

    assign w_rot = {i_x, i_x} >> i_n;

    always_comb begin
        o_y = i_x;
        case (i_type)
            SH_LSL:  o_y = i_x << i_n;
            SH_LSR:  o_y = i_x >> i_n;
            SH_ASR:  o_y = 32'($signed(i_x) >>> i_n);
            SH_ROR:  o_y = w_rot[31:0];
            default: o_y = i_x;
        endcase
    end
endmodule

// File: rtl/shift_arbiter.sv
// Shares one shifter among NUM_REQ requesters with ARM register-shift
// semantics and a single registered result stage.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input logic            clk,
    input logic            rst_n,
    shift_arbiter_if.slave bus
);
    logic               r_valid;
    logic [31:0]        r_data;
    logic               r_carry;
    logic [ID_W-1:0]    r_id;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_id;
    logic               w_any;
    logic               w_en;
    int                 w_sel;
    shift_t             w_type;
    logic [7:0]         w_amt;
    logic [31:0]        w_x;
    logic               w_cin;
    logic [4:0]         w_n;
    logic [4:0]         w_lsl_i;
    logic [4:0]         w_lsr_i;
    logic               w_big;
    logic               w_eq32;
    logic [31:0]        w_sh;
    logic [31:0]        w_y;
    logic               w_c;

    // req_ready must drop immediately while reset is held.
    assign w_en = rst_n & (~r_valid | bus.res_ready);

    shift_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (bus.req_valid),
        .i_en  (w_en),
        .o_gnt (w_gnt),
        .o_id  (w_id),
        .o_any (w_any)
    );

    assign bus.req_ready = w_gnt;

    assign w_sel  = int'(w_id);
    assign w_type = shift_t'(bus.req_type[w_sel*2 +: 2]);
    assign w_amt  = bus.req_amount[w_sel*AMT_W +: AMT_W];
    assign w_x    = bus.req_data[w_sel*DATA_W +: DATA_W];
    assign w_cin  = bus.req_cin[w_sel];

    assign w_n     = w_amt[4:0];
    assign w_lsl_i = 5'd0 - w_n;
    assign w_lsr_i = w_n - 5'd1;
    assign w_big   = |w_amt[7:5];
    assign w_eq32  = (w_amt == 8'd32);

    shift_arbiter_shifter u_shifter (
        .i_type (w_type),
        .i_n    (w_n),
        .i_x    (w_x),
        .o_y    (w_sh)
    );

    always_comb begin
        w_y = w_x;
        w_c = w_cin;
        if (w_amt != 8'd0) begin
            case (w_type)
                SH_LSL: begin
                    w_y = w_big ? 32'd0 : w_sh;
                    w_c = w_big ? (w_eq32 & w_x[0]) : w_x[w_lsl_i];
                end
                SH_LSR: begin
                    w_y = w_big ? 32'd0 : w_sh;
                    w_c = w_big ? (w_eq32 & w_x[31]) : w_x[w_lsr_i];
                end
                SH_ASR: begin
                    w_y = w_big ? {32{w_x[31]}} : w_sh;
                    w_c = w_big ? w_x[31] : w_x[w_lsr_i];
                end
                default: begin
                    w_y = (w_n == 5'd0) ? w_x : w_sh;
                    w_c = (w_n == 5'd0) ? w_x[31] : w_sh[31];
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
        end else if (w_any) begin
            r_valid <= 1'b1;
            r_data  <= w_y;
            r_carry <= w_c;
            r_id    <= w_id;
        end else if (bus.res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.res_valid = r_valid;
    assign bus.res_data  = r_data;
    assign bus.res_carry = r_carry;
    assign bus.res_id    = r_id;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: arbitration, boundary shifts,
// backpressure and asynchronous reset.
module tb_shift_arbiter;
    import shift_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    shift_arbiter_if #(.NUM_REQ(2), .ID_W(1)) bus ();

    shift_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input shift_t ty,
                           input logic [7:0] a, input logic [31:0] x,
                           input logic ci);
        bus.req_type[id*2 +: 2]     = ty;
        bus.req_amount[id*8 +: 8]   = a;
        bus.req_data[id*32 +: 32]   = x;
        bus.req_cin[id]             = ci;
    endtask

    task automatic op(input string tag, input int id, input shift_t ty,
                      input logic [7:0] a, input logic [31:0] x,
                      input logic ci, input logic [31:0] ey,
                      input logic ec);
        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.req_valid = '0;
        set_req(id, ty, a, x, ci);
        bus.req_valid[id] = 1'b1;
        #1;
        chk({tag, ".rdy"}, 32'(bus.req_ready), 32'(1 << id));
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        chk({tag, ".vld"}, 32'(bus.res_valid), 32'd1);
        chk({tag, ".y"}, bus.res_data, ey);
        chk({tag, ".c"}, 32'(bus.res_carry), 32'(ec));
        chk({tag, ".id"}, 32'(bus.res_id), 32'(id));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_type   = '0;
        bus.req_amount = '0;
        bus.req_data   = '0;
        bus.req_cin    = '0;
        bus.res_ready  = 1'b1;

        #12;
        chk("rst.vld", 32'(bus.res_valid), 32'd0);
        chk("rst.y", bus.res_data, 32'd0);
        chk("rst.c", 32'(bus.res_carry), 32'd0);
        chk("rst.id", 32'(bus.res_id), 32'd0);
        chk("rst.rdy", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;

        op("lsl1",   0, SH_LSL, 8'd1,  32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        op("lsl32",  1, SH_LSL, 8'd32, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1);
        op("lsl33",  0, SH_LSL, 8'd33, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b0);
        op("asr40",  1, SH_ASR, 8'd40, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1);
        op("lsr32",  0, SH_LSR, 8'd32, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);
        op("ror1",   1, SH_ROR, 8'd1,  32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1);
        op("ror32",  0, SH_ROR, 8'd32, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0);
        op("ror0",   1, SH_ROR, 8'd0,  32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1);
        op("asr4",   0, SH_ASR, 8'd4,  32'h8000_0000, 1'b1, 32'hF800_0000, 1'b0);
        op("ror36",  1, SH_ROR, 8'd36, 32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1);
        op("lsr4",   0, SH_LSR, 8'd4,  32'h0000_00F8, 1'b0, 32'h0000_000F, 1'b1);
        op("lsl0",   1, SH_LSL, 8'd0,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0);

        // Leave pointer at 1 with a result pending, then reset mid-flight.
        op("pre", 0, SH_LSL, 8'd1, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1);
        @(negedge clk);
        bus.res_ready = 1'b0;
        set_req(1, SH_LSR, 8'd4, 32'h0000_00F0, 1'b0);
        bus.req_valid = 2'b11;
        #1;
        chk("hold.rdy", 32'(bus.req_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.vld", 32'(bus.res_valid), 32'd0);
        chk("arst.rdy", 32'(bus.req_ready), 32'd0);
        chk("arst.y", bus.res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        #1;
        chk("ptr0.rdy", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("rr.rdy", 32'(bus.req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
            chk("rr.id", 32'(bus.res_id), 32'(i % 2));
            chk("rr.y", bus.res_data,
                (i % 2 == 0) ? 32'h0000_0002 : 32'h0000_000F);
            chk("rr.c", 32'(bus.res_carry), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        @(negedge clk);
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.rdy", 32'(bus.req_ready), 32'd0);
            chk("bp.vld", 32'(bus.res_valid), 32'd1);
            chk("bp.y", bus.res_data, 32'h0000_000F);
            chk("bp.id", 32'(bus.res_id), 32'd1);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("rel.rdy", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        chk("rel.id", 32'(bus.res_id), 32'd0);
        chk("rel.y", bus.res_data, 32'h0000_0002);
        chk("rel.c", 32'(bus.res_carry), 32'd1);
        @(posedge clk);
        #1;
        chk("drain.vld", 32'(bus.res_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
